// File: rtl/sram_2p_march_bist_if.sv
// sram_2p_march_bist_if: BIST pin bundle between the March engine and a two-port SRAM macro
interface sram_2p_march_bist_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              bist_en;
  logic              a_men;
  logic              a_wen;
  logic              a_ren;
  logic              b_men;
  logic              b_wen;
  logic              b_ren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] bm;
  logic [DATA_W-1:0] a_dout;
  logic [DATA_W-1:0] b_dout;
  modport master (
    output bist_en, a_men, a_wen, a_ren, b_men, b_wen, b_ren, addr, din, bm,
    input  a_dout, b_dout
  );
  modport slave (
    input  bist_en, a_men, a_wen, a_ren, b_men, b_wen, b_ren, addr, din, bm,
    output a_dout, b_dout
  );
endinterface

// File: rtl/sram_2p_march_bist.sv
// sram_2p_march_bist: March C- BIST engine with on-line compare for a two-port SRAM macro
module sram_2p_march_bist #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 10,
  parameter int                DEPTH     = 1024,
  parameter int                NUM_PORTS = 2,
  parameter int                READ_LAT  = 1,
  parameter logic [DATA_W-1:0] DATA_BG   = '0,
  parameter int                FCNT_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 fail_port_o,
  output logic [ADDR_W-1:0]    fail_addr_o,
  output logic [2:0]           fail_elem_o,
  output logic [FCNT_W-1:0]    fail_cnt_o,
  sram_2p_march_bist_if.master mem
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef struct packed {
    logic              vld;
    logic              port;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        elem;
    logic              one;
  } rd_t;
  typedef struct packed {
    logic              en;
    logic              a_men;
    logic              a_wen;
    logic              a_ren;
    logic              b_men;
    logic              b_wen;
    logic              b_ren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] bm;
  } op_t;
  localparam logic [ADDR_W:0] LAST      = (ADDR_W+1)'(DEPTH-1);
  localparam logic [1:0]      DRAIN_END = 2'(READ_LAT-1);
  localparam logic            PORT_END  = 1'(NUM_PORTS-1);
  state_e            state_q, state_d;
  logic              port_q, port_d, phase_q, phase_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [1:0]        drain_q, drain_d;
  op_t               op_q, op_d;
  rd_t               pipe_q [READ_LAT+1];
  rd_t               rd_d;
  logic              run, wr, val, down, last_op, addr_end, mis;
  logic              fail_q, pass_q, done_q, fport_q;
  logic [ADDR_W-1:0] faddr_q;
  logic [2:0]        felem_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [DATA_W-1:0] dout, exp_data;
  assign down     = elem_q == 3'd3 || elem_q == 3'd4;
  assign last_op  = phase_q || elem_q == 3'd0 || elem_q == 3'd5;
  assign addr_end = down ? addr_q == '0 : addr_q == LAST;
  assign dout     = pipe_q[READ_LAT].port ? mem.b_dout : mem.a_dout;
  assign exp_data = pipe_q[READ_LAT].one ? ~DATA_BG : DATA_BG;
  assign mis      = pipe_q[READ_LAT].vld && dout != exp_data;
  // March sequencer: r/w phase, then address, then element, then port, then drain and done
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    phase_d = phase_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        port_d  = 1'b0;
        phase_d = 1'b0;
        elem_d  = '0;
        addr_d  = '0;
      end
      RUN: if (!last_op) phase_d = 1'b1;
      else if (!addr_end) begin
        phase_d = 1'b0;
        addr_d  = down ? addr_q - 1'b1 : addr_q + 1'b1;
      end else if (elem_q != 3'd5) begin
        phase_d = 1'b0;
        elem_d  = elem_q + 3'd1;
        addr_d  = (elem_q == 3'd2 || elem_q == 3'd3) ? LAST : '0;
      end else if (port_q != PORT_END) begin
        port_d  = 1'b1;
        phase_d = 1'b0;
        elem_d  = '0;
        addr_d  = '0;
      end else begin
        state_d = DRAIN;
        drain_d = '0;
      end
      DRAIN: begin
        state_d = drain_q == DRAIN_END ? DONE : DRAIN;
        drain_d = drain_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Decode next cycle's op so the macro pins and the compare tag come straight from flops
  always_comb begin
    run        = state_d == RUN;
    wr         = run && (elem_d == 3'd0 || phase_d);
    val        = wr ? elem_d[0] : ~elem_d[0];
    op_d.en    = run || state_d == DRAIN;
    op_d.a_men = run && !port_d;
    op_d.a_wen = wr && !port_d;
    op_d.a_ren = run && !wr && !port_d;
    op_d.b_men = run && port_d;
    op_d.b_wen = wr && port_d;
    op_d.b_ren = run && !wr && port_d;
    op_d.addr  = run ? addr_d[ADDR_W-1:0] : '0;
    op_d.din   = wr ? (val ? ~DATA_BG : DATA_BG) : '0;
    op_d.bm    = {DATA_W{wr}};
    rd_d       = '{vld: run && !wr, port: port_d, addr: addr_d[ADDR_W-1:0], elem: elem_d, one: val};
  end
  // Sequencer state, registered macro pins and the read-tag shift register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      port_q  <= 1'b0;
      phase_q <= 1'b0;
      elem_q  <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      op_q    <= '0;
      for (int i = 0; i <= READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      phase_q   <= phase_d;
      elem_q    <= elem_d;
      addr_q    <= addr_d;
      drain_q   <= drain_d;
      op_q      <= op_d;
      pipe_q[0] <= rd_d;
      for (int i = 1; i <= READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  // Results: clear on start, snapshot the first miscompare, saturate the count, verdict at done
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      fport_q <= 1'b0;
      faddr_q <= '0;
      felem_q <= '0;
      fcnt_q  <= '0;
    end else begin
      done_q <= state_d == DONE;
      if (state_q == IDLE && start_i) begin
        pass_q  <= 1'b0;
        fail_q  <= 1'b0;
        fport_q <= 1'b0;
        faddr_q <= '0;
        felem_q <= '0;
        fcnt_q  <= '0;
      end else if (mis) begin
        fail_q <= 1'b1;
        if (!fail_q) begin
          fport_q <= pipe_q[READ_LAT].port;
          faddr_q <= pipe_q[READ_LAT].addr;
          felem_q <= pipe_q[READ_LAT].elem;
        end
        if (fcnt_q != '1) fcnt_q <= fcnt_q + 1'b1;
      end
      if (state_d == DONE) pass_q <= !(fail_q || mis);
    end
  end
  assign busy_o      = op_q.en;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign fail_port_o = fport_q;
  assign fail_addr_o = faddr_q;
  assign fail_elem_o = felem_q;
  assign fail_cnt_o  = fcnt_q;
  assign mem.bist_en = op_q.en;
  assign mem.a_men   = op_q.a_men;
  assign mem.a_wen   = op_q.a_wen;
  assign mem.a_ren   = op_q.a_ren;
  assign mem.b_men   = op_q.b_men;
  assign mem.b_wen   = op_q.b_wen;
  assign mem.b_ren   = op_q.b_ren;
  assign mem.addr    = op_q.addr;
  assign mem.din     = op_q.din;
  assign mem.bm      = op_q.bm;
endmodule

// File: tb/tb_sram_2p_march_bist.sv
// tb_sram_2p_march_bist: scoreboard bench with a behavioural macro and an abstract March C- model
module tb_sram_2p_march_bist;
  typedef struct {
    int id;
    int pass;
    int fail;
    int port;
    int addr;
    int elem;
    int cnt;
    int busy;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [2] = '{1'b0, 1'b0};
  logic       busy [2], done [2], pass [2], fail [2], fport [2];
  logic [3:0] faddr [2];
  logic [2:0] felem [2];
  logic [7:0] fcnt [2];
  logic       f_en [2] = '{1'b0, 1'b0};
  logic       f_val [2] = '{1'b0, 1'b0};
  int         f_port [2] = '{0, 0};
  int         f_addr [2] = '{0, 0};
  int         f_bit [2] = '{0, 0};
  exp_t       sbq [$];
  exp_t       mon_e;
  int         bcnt [2] = '{0, 0};
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  sram_2p_march_bist_if #(.DATA_W(8), .ADDR_W(4)) mif [2] ();

  sram_2p_march_bist #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .NUM_PORTS(2), .READ_LAT(1),
                       .DATA_BG(8'h00), .FCNT_W(8)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
    .pass_o(pass[0]), .fail_o(fail[0]), .fail_port_o(fport[0]), .fail_addr_o(faddr[0]),
    .fail_elem_o(felem[0]), .fail_cnt_o(fcnt[0]), .mem(mif[0]));

  sram_2p_march_bist #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .NUM_PORTS(2), .READ_LAT(3),
                       .DATA_BG(8'h5A), .FCNT_W(8)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
    .pass_o(pass[1]), .fail_o(fail[1]), .fail_port_o(fport[1]), .fail_addr_o(faddr[1]),
    .fail_elem_o(felem[1]), .fail_cnt_o(fcnt[1]), .mem(mif[1]));

  // Behavioural two-port macro: shared array, per-port read pipeline, optional read-path stuck bit
  for (genvar g = 0; g < 2; g++) begin : mm
    localparam int RL  = g ? 3 : 1;
    localparam int DEP = g ? 12 : 16;
    logic [7:0]  m [16];
    logic [7:0]  ra [3];
    logic [7:0]  rb [3];
    logic [7:0]  fa, fb;
    logic [26:0] pins;
    int          viol = 0;
    assign pins = {mif[g].bist_en, mif[g].a_men, mif[g].a_wen, mif[g].a_ren, mif[g].b_men,
                   mif[g].b_wen, mif[g].b_ren, mif[g].addr, mif[g].din, mif[g].bm};
    assign mif[g].a_dout = ra[RL-1];
    assign mif[g].b_dout = rb[RL-1];
    always_comb begin
      fa = m[mif[g].addr];
      fb = fa;
      if (f_en[g] && mif[g].addr == 4'(f_addr[g])) begin
        if (f_port[g] == 0) fa[f_bit[g]] = f_val[g];
        else fb[f_bit[g]] = f_val[g];
      end
    end
    always @(posedge clk) begin
      if ((mif[g].a_men && mif[g].b_men) ||
          ((mif[g].a_men || mif[g].b_men) && int'(mif[g].addr) >= DEP) ||
          ((mif[g].a_wen || mif[g].b_wen) && mif[g].bm != 8'hFF) ||
          ((mif[g].a_wen || mif[g].a_ren) && !mif[g].a_men) ||
          ((mif[g].b_wen || mif[g].b_ren) && !mif[g].b_men) ||
          ((mif[g].a_men || mif[g].b_men) && !mif[g].bist_en))
        viol <= viol + 1;
      if ((mif[g].a_men && mif[g].a_wen) || (mif[g].b_men && mif[g].b_wen))
        m[mif[g].addr] <= (m[mif[g].addr] & ~mif[g].bm) | (mif[g].din & mif[g].bm);
      if (mif[g].a_men && mif[g].a_ren) ra[0] <= fa;
      if (mif[g].b_men && mif[g].b_ren) rb[0] <= fb;
      ra[1] <= ra[0];
      ra[2] <= ra[1];
      rb[1] <= rb[0];
      rb[2] <= rb[1];
    end
  end

  // Reference: walk the March C- element table over an abstract memory and note every bad read
  function automatic exp_t model(input int id, input int fen, input int fp, input int fad,
                                 input int fbit, input int fv);
    int         dep = id ? 12 : 16;
    logic [7:0] bg = id ? 8'h5A : 8'h00;
    int         rv [6] = '{0, 0, 1, 0, 1, 0};
    int         wv [6] = '{0, 1, 0, 1, 0, 0};
    logic [7:0] mem [16];
    logic [7:0] obs, want;
    exp_t       e = '{id, 0, 0, 0, 0, 0, 0, 20 * dep + (id ? 3 : 1)};
    for (int p = 0; p < 2; p++)
      for (int el = 0; el < 6; el++)
        for (int k = 0; k < dep; k++) begin
          int a;
          a = (el == 3 || el == 4) ? dep - 1 - k : k;
          if (el != 0) begin
            obs = mem[a];
            if (fen != 0 && p == fp && a == fad) obs[fbit] = 1'(fv);
            want = rv[el] != 0 ? ~bg : bg;
            if (obs != want) begin
              if (e.fail == 0) begin
                e.fail = 1;
                e.port = p;
                e.addr = a;
                e.elem = el;
              end
              if (e.cnt < 255) e.cnt++;
            end
          end
          if (el != 5) mem[a] = wv[el] != 0 ? ~bg : bg;
        end
    e.pass = 1 - e.fail;
    return e;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, want);
  endtask

  task automatic zero_check(input int id, input string nm);
    check({nm, "_status"}, {busy[id], done[id], pass[id], fail[id], fport[id], faddr[id],
                            felem[id], fcnt[id]}, 64'd0);
    check({nm, "_pins"}, id != 0 ? mm[1].pins : mm[0].pins, 64'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000 && sbq.size() != 0; i++) @(negedge clk);
    check("done_seen", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic run(input int id, input int fen, input int fp, input int fad, input int fbit,
                     input int fv, input bit retrig);
    exp_t e;
    f_en[id]   = fen != 0;
    f_port[id] = fp;
    f_addr[id] = fad;
    f_bit[id]  = fbit;
    f_val[id]  = 1'(fv);
    e = model(id, fen, fp, fad, fbit, fv);
    sbq.push_back(e);
    @(negedge clk);
    start[id] = 1'b1;
    @(negedge clk);
    start[id] = 1'b0;
    if (retrig) begin
      repeat (9) @(negedge clk);
      start[id] = 1'b1;
      @(negedge clk);
      start[id] = 1'b0;
    end
    wait_done();
    repeat (3) @(negedge clk);
    check("verdict_hold", {pass[id], fail[id]}, {62'd0, e.pass[0], e.fail[0]});
  endtask

  // Monitor: count busy cycles and score every done pulse against the queued expectation
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) bcnt[g] = 0;
      else begin
        if (busy[g]) bcnt[g]++;
        if (done[g]) begin
          check("done_owner", sbq.size() != 0 ? sbq[0].id : -1, g);
          if (sbq.size() != 0 && sbq[0].id == g) begin
            mon_e = sbq.pop_front();
            check("pass", pass[g], mon_e.pass);
            check("fail", fail[g], mon_e.fail);
            check("fail_port", fport[g], mon_e.port);
            check("fail_addr", faddr[g], mon_e.addr);
            check("fail_elem", felem[g], mon_e.elem);
            check("fail_cnt", fcnt[g], mon_e.cnt);
            check("busy_cycles", bcnt[g], mon_e.busy);
          end
          bcnt[g] = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int id;
    repeat (3) @(negedge clk);
    zero_check(0, "reset0");
    zero_check(1, "reset1");
    rst_n = 1'b1;
    run(0, 0, 0, 0, 0, 0, 1'b0);
    run(0, 1, 0, 5, 3, 1, 1'b0);
    run(0, 1, 1, 15, 0, 0, 1'b0);
    f_en[0] = 1'b0;
    sbq.push_back(model(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (39) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 zero_check(0, "midrun_rst");
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_after_rst", {done[0], busy[0]}, 64'd0);
    run(0, 0, 0, 0, 0, 0, 1'b0);
    run(0, 0, 0, 0, 0, 0, 1'b1);
    run(1, 0, 0, 0, 0, 0, 1'b0);
    run(1, 1, 1, 11, 7, 0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      id = int'($urandom_range(0, 1));
      run(id, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
          int'($urandom_range(0, id != 0 ? 11 : 15)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 1)), 1'b0);
    end
    check("macro_rules0", mm[0].viol, 0);
    check("macro_rules1", mm[1].viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
